wb_spi_flash_rd: RTL and testbench

WB_SPI_FLASH_RD -- requirements
Module: wb_spi_flash_rd

---
 rtl/wb_spi_flash_rd.sv | 140 ++++++++++++++
 tb/tb_wb_spi_flash_rd.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_spi_flash_rd.sv
// Wishbone classic slave that serves 32-bit reads from a SPI NOR flash using
// the 0x03 READ command in SPI mode 0. Writes are refused with wb_err_o.
module wb_spi_flash_rd #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        spi_sck_o,
  output logic        spi_cs_n_o,
  output logic        spi_mosi_o,
  input  logic        spi_miso_i
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [63:0] tx, tx_nxt;
  logic [31:0] rx, rx_nxt;
  logic [5:0]  bit_cnt, bit_nxt;
  logic [7:0]  div_cnt, div_nxt;
  logic        sck_nxt, cs_n_nxt, mosi_nxt, ack_nxt, err_nxt;
  logic [31:0] dat_nxt;
  logic        req, half_end, sample;
  logic        unused_inputs;

  assign unused_inputs = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:24], wb_adr_i[1:0]};

  assign req      = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~wb_err_o;
  assign half_end = (div_cnt == DIV_LAST);
  // First cycle of the SCK-high half, data bits (32..63) only.
  assign sample   = spi_sck_o && (div_cnt == '0) && bit_cnt[5];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      tx         <= '0;
      rx         <= '0;
      bit_cnt    <= '0;
      div_cnt    <= '0;
      spi_sck_o  <= 1'b0;
      spi_cs_n_o <= 1'b1;
      spi_mosi_o <= 1'b0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= '0;
    end else begin
      state      <= state_nxt;
      tx         <= tx_nxt;
      rx         <= rx_nxt;
      bit_cnt    <= bit_nxt;
      div_cnt    <= div_nxt;
      spi_sck_o  <= sck_nxt;
      spi_cs_n_o <= cs_n_nxt;
      spi_mosi_o <= mosi_nxt;
      wb_ack_o   <= ack_nxt;
      wb_err_o   <= err_nxt;
      wb_dat_o   <= dat_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    tx_nxt    = tx;
    rx_nxt    = rx;
    bit_nxt   = bit_cnt;
    div_nxt   = div_cnt;
    sck_nxt   = 1'b0;
    cs_n_nxt  = 1'b1;
    mosi_nxt  = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    dat_nxt   = '0;

    case (state)
      IDLE: begin
        if (req) begin
          if (wb_we_i) begin
            err_nxt = 1'b1;
          end else begin
            state_nxt = XFER;
            tx_nxt    = {8'h03, wb_adr_i[23:2], 2'b00, 32'h0};
            rx_nxt    = '0;
            bit_nxt   = '0;
            div_nxt   = '0;
            cs_n_nxt  = 1'b0;
            mosi_nxt  = tx_nxt[63];
          end
        end
      end

      XFER: begin
        if (!wb_cyc_i) begin
          state_nxt = IDLE;
        end else begin
          cs_n_nxt = 1'b0;
          sck_nxt  = spi_sck_o;
          mosi_nxt = spi_mosi_o;
          if (sample)
            rx_nxt = {rx[30:0], spi_miso_i};
          div_nxt = half_end ? '0 : div_cnt + 8'd1;
          if (half_end) begin
            if (!spi_sck_o) begin
              sck_nxt = 1'b1;
            end else if (bit_cnt == 6'd63) begin
              // With CLK_DIV=1 the last sample and the frame end share a cycle,
              // so the returned word is taken from rx_nxt.
              state_nxt = DONE;
              cs_n_nxt  = 1'b1;
              sck_nxt   = 1'b0;
              mosi_nxt  = 1'b0;
              ack_nxt   = 1'b1;
              dat_nxt   = {rx_nxt[7:0], rx_nxt[15:8], rx_nxt[23:16], rx_nxt[31:24]};
            end else begin
              sck_nxt  = 1'b0;
              tx_nxt   = {tx[62:0], 1'b0};
              mosi_nxt = tx[62];
              bit_nxt  = bit_cnt + 6'd1;
            end
          end
        end
      end

      DONE: state_nxt = IDLE;

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wb_spi_flash_rd.sv
// Directed bench for wb_spi_flash_rd: one instance at CLK_DIV=2, one at
// CLK_DIV=1, each driving a behavioural SPI flash model.
module tb_wb_spi_flash_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [1:0]  cyc_v, stb_v, we_v, ack_v, err_v, sck_v, cs_v, mosi_v, miso_v;
  logic [31:0] adr_v  [2];
  logic [31:0] wdat_v [2];
  logic [31:0] rdat_v [2];
  logic [3:0]  sel;

  int tests = 0;
  int fails = 0;

  wb_spi_flash_rd #(.CLK_DIV(2)) dut_div2 (
    .clk(clk), .reset_n(rst_n),
    .wb_adr_i(adr_v[0]), .wb_dat_i(wdat_v[0]), .wb_sel_i(sel),
    .wb_we_i(we_v[0]), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb_v[0]),
    .wb_dat_o(rdat_v[0]), .wb_ack_o(ack_v[0]), .wb_err_o(err_v[0]),
    .spi_sck_o(sck_v[0]), .spi_cs_n_o(cs_v[0]), .spi_mosi_o(mosi_v[0]),
    .spi_miso_i(miso_v[0])
  );

  wb_spi_flash_rd #(.CLK_DIV(1)) dut_div1 (
    .clk(clk), .reset_n(rst_n),
    .wb_adr_i(adr_v[1]), .wb_dat_i(wdat_v[1]), .wb_sel_i(sel),
    .wb_we_i(we_v[1]), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb_v[1]),
    .wb_dat_o(rdat_v[1]), .wb_ack_o(ack_v[1]), .wb_err_o(err_v[1]),
    .spi_sck_o(sck_v[1]), .spi_cs_n_o(cs_v[1]), .spi_mosi_o(mosi_v[1]),
    .spi_miso_i(miso_v[1])
  );

  // Flash contents: bit k of the frame (k >= 32) is data bit 7-(k%8) of byte
  // cmd_addr + (k-32)/8.
  function automatic logic flash_bit(input logic [31:0] cmd, input int k);
    logic [23:0] a;
    logic [7:0]  b;
    if (k < 32) return 1'b0;
    a = cmd[23:0] + 24'((k - 32) / 8);
    case (a)
      24'h000100: b = 8'hEF;
      24'h000101: b = 8'hBE;
      24'h000102: b = 8'hAD;
      24'h000103: b = 8'hDE;
      24'h000104: b = 8'h78;
      24'h000105: b = 8'h56;
      24'h000106: b = 8'h34;
      24'h000107: b = 8'h12;
      default:    b = 8'h00;
    endcase
    return b[7 - ((k - 32) % 8)];
  endfunction

  int          rise [2];
  int          fall [2];
  logic [31:0] cmd  [2];
  logic [1:0]  psck;

  // Flash model: captures the first 32 MOSI bits on SCK rise, shifts the next
  // MISO bit out after each SCK fall.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (cs_v[i] === 1'b1) begin
        rise[i] = 0;
        fall[i] = 0;
        miso_v[i] <= 1'b0;
      end else begin
        if (sck_v[i] === 1'b1 && psck[i] === 1'b0) begin
          if (rise[i] < 32) cmd[i] = {cmd[i][30:0], mosi_v[i]};
          rise[i]++;
        end
        if (sck_v[i] === 1'b0 && psck[i] === 1'b1) begin
          fall[i]++;
          miso_v[i] <= flash_bit(cmd[i], fall[i]);
        end
      end
      psck[i] = sck_v[i];
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wb_read(input int i, input logic [31:0] addr, input logic [31:0] exp_cmd,
                         input logic [31:0] exp_dat, input int exp_lat, input bit hold);
    int n, cs_low, errs;
    @(negedge clk);
    check("cs_idle_before_read", 64'(cs_v[i]), 64'd1);
    adr_v[i] = addr;
    we_v[i]  = 1'b0;
    cyc_v[i] = 1'b1;
    stb_v[i] = 1'b1;
    n = 0; cs_low = 0; errs = 0;
    do begin
      @(negedge clk);
      n++;
      if (cs_v[i] === 1'b0) cs_low++;
      if (err_v[i] !== 1'b0) errs++;
    end while (ack_v[i] !== 1'b1 && n < 2000);
    check("ack_latency", 64'(n), 64'(exp_lat));
    check("read_data", 64'(rdat_v[i]), 64'(exp_dat));
    check("cs_low_cycles", 64'(cs_low), 64'(exp_lat - 1));
    check("mosi_cmd_addr", 64'(cmd[i]), 64'(exp_cmd));
    check("no_err_on_read", 64'(errs), 64'd0);
    if (!hold) begin
      cyc_v[i] = 1'b0;
      stb_v[i] = 1'b0;
      @(negedge clk);
      check("ack_single_cycle", 64'(ack_v[i]), 64'd0);
      check("dat_zero_after_ack", 64'(rdat_v[i]), 64'd0);
    end
  endtask

  initial begin
    int acks, cs_lows;
    sel = 4'hF;
    cyc_v = '0; stb_v = '0; we_v = '0;
    for (int i = 0; i < 2; i++) begin
      adr_v[i]  = '0;
      wdat_v[i] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", 64'(ack_v[0]), 64'd0);
    check("rst_err", 64'(err_v[0]), 64'd0);
    check("rst_dat", 64'(rdat_v[0]), 64'd0);
    check("rst_cs_n", 64'(cs_v[0]), 64'd1);
    check("rst_sck", 64'(sck_v[0]), 64'd0);
    check("rst_mosi", 64'(mosi_v[0]), 64'd0);
    rst_n = 1'b1;

    // Basic read and address masking
    wb_read(0, 32'h0000_0100, 32'h0300_0100, 32'hDEAD_BEEF, 257, 1'b0);
    wb_read(0, 32'hAB00_0103, 32'h0300_0100, 32'hDEAD_BEEF, 257, 1'b0);

    // Write request is refused
    @(negedge clk);
    adr_v[0] = 32'h0000_0100; wdat_v[0] = 32'h1234_5678;
    we_v[0] = 1'b1; cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
    @(negedge clk);
    check("wr_err", 64'(err_v[0]), 64'd1);
    check("wr_no_ack", 64'(ack_v[0]), 64'd0);
    check("wr_cs_high", 64'(cs_v[0]), 64'd1);
    we_v[0] = 1'b0; cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
    @(negedge clk);
    check("wr_err_one_cycle", 64'(err_v[0]), 64'd0);
    acks = 0; cs_lows = 0;
    repeat (10) begin
      @(negedge clk);
      if (ack_v[0] !== 1'b0) acks++;
      if (cs_v[0] !== 1'b1) cs_lows++;
    end
    check("wr_no_later_ack", 64'(acks), 64'd0);
    check("wr_no_spi", 64'(cs_lows), 64'd0);

    // Abort by dropping cyc at t+40
    @(negedge clk);
    adr_v[0] = 32'h0000_0100; cyc_v[0] = 1'b1; stb_v[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("abort_cs_low_before", 64'(cs_v[0]), 64'd0);
    cyc_v[0] = 1'b0; stb_v[0] = 1'b0;
    @(negedge clk);
    check("abort_cs_high", 64'(cs_v[0]), 64'd1);
    check("abort_sck_low", 64'(sck_v[0]), 64'd0);
    check("abort_no_ack", 64'(ack_v[0]), 64'd0);
    check("abort_no_err", 64'(err_v[0]), 64'd0);
    acks = 0;
    repeat (20) begin
      @(negedge clk);
      if (ack_v[0] !== 1'b0) acks++;
    end
    check("abort_no_late_ack", 64'(acks), 64'd0);
    wb_read(0, 32'h0000_0100, 32'h0300_0100, 32'hDEAD_BEEF, 257, 1'b0);

    // Reset mid-read on the CLK_DIV=1 instance
    @(negedge clk);
    adr_v[1] = 32'h0000_0100; cyc_v[1] = 1'b1; stb_v[1] = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_mid_cs_low", 64'(cs_v[1]), 64'd0);
    rst_n = 1'b0;
    cyc_v[1] = 1'b0; stb_v[1] = 1'b0;
    @(negedge clk);
    check("rst_mid_ack", 64'(ack_v[1]), 64'd0);
    check("rst_mid_err", 64'(err_v[1]), 64'd0);
    check("rst_mid_dat", 64'(rdat_v[1]), 64'd0);
    check("rst_mid_cs_n", 64'(cs_v[1]), 64'd1);
    check("rst_mid_sck", 64'(sck_v[1]), 64'd0);
    check("rst_mid_mosi", 64'(mosi_v[1]), 64'd0);
    rst_n = 1'b1;
    acks = 0;
    repeat (40) begin
      @(negedge clk);
      if (ack_v[1] !== 1'b0) acks++;
    end
    check("rst_mid_no_ack", 64'(acks), 64'd0);
    wb_read(1, 32'h0000_0100, 32'h0300_0100, 32'hDEAD_BEEF, 129, 1'b0);

    // Back-to-back reads
    wb_read(0, 32'h0000_0100, 32'h0300_0100, 32'hDEAD_BEEF, 257, 1'b1);
    wb_read(0, 32'h0000_0104, 32'h0300_0104, 32'h1234_5678, 257, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
